mpsk_symbol_mapper: RTL and testbench

Parametrised M-PSK modulator core, successor to the fixed QPSK phase-select path.
- Collects serial bits (from the DRBG or any bit source) into BITS_PER_SYM-bit symbols through a valid/ready handshake.
- Maps each symbol to a phase index (optional Gray mapping) and holds it for SAMPLES_PER_SYM clocks.
- Emits a per-sample carrier phase word for a downstream sine LUT/DAC.
- Supports BPSK/QPSK/8PSK/16PSK from one RTL source.

---
 rtl/mpsk_symbol_mapper_if.sv | 29 ++
 rtl/mpsk_symbol_mapper.sv | 197 +++++++++++++++++++
 tb/tb_mpsk_symbol_mapper.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpsk_symbol_mapper_if.sv
// Bit-stream in / phase-stream out bundle for the M-PSK symbol mapper.
// Latency: none (wires only).
// Backpressure: bit_ready qualifies bit_valid; the phase side has no backpressure.
interface mpsk_symbol_mapper_if #(
    parameter int BITS_PER_SYM = 2,
    parameter int PHASE_W      = 8
);
    logic                    bit_in;
    logic                    bit_valid;
    logic                    bit_ready;
    logic                    enable;
    logic [BITS_PER_SYM-1:0] sym_out;
    logic                    sym_valid;
    logic                    sym_strobe;
    logic [PHASE_W-1:0]      phase_out;
    logic                    underrun;

    // Bit source / consumer side.
    modport master (
        output bit_in, bit_valid, enable,
        input  bit_ready, sym_out, sym_valid, sym_strobe, phase_out, underrun
    );

    // Mapper side.
    modport slave (
        input  bit_in, bit_valid, enable,
        output bit_ready, sym_out, sym_valid, sym_strobe, phase_out, underrun
    );
endinterface

// File: rtl/mpsk_symbol_mapper.sv
// M-PSK mapper: serial bits -> symbol -> phase index -> per-sample carrier phase word.
// Latency: symbol loads one clock after its last bit; outputs registered (visible after the load edge).
// Backpressure: bit_ready low only when collector is on its last bit and the pending slot is full and not draining.
// Optional: define MPSK_DIFF_ENC_EN for differential phase encoding (prev_idx accumulator).
module mpsk_symbol_mapper #(
    parameter int BITS_PER_SYM    = 2,
    parameter int SAMPLES_PER_SYM = 8,
    parameter int PHASE_W         = 8,
    parameter int GRAY            = 1
) (
    input logic                clk,
    input logic                rst,
    mpsk_symbol_mapper_if.slave bus
);
    localparam int CNT_W  = (BITS_PER_SYM > 1) ? $clog2(BITS_PER_SYM) : 1;
    localparam int SCNT_W = $clog2(SAMPLES_PER_SYM);
    localparam int OFS_SH = PHASE_W - BITS_PER_SYM;

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(BITS_PER_SYM - 1);
    localparam logic [SCNT_W-1:0]  SCNT_LAST = SCNT_W'(SAMPLES_PER_SYM - 1);
    // One full carrier cycle per symbol.
    localparam logic [PHASE_W-1:0] STEP      = PHASE_W'((1 << PHASE_W) / SAMPLES_PER_SYM);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Collector and pending buffer
    logic [BITS_PER_SYM-1:0] shreg;
    logic [CNT_W-1:0]        cnt;
    logic [BITS_PER_SYM-1:0] word_next;
    logic [BITS_PER_SYM-1:0] pend_word;
    logic                    pend_full;
    logic                    pend_take;
    logic                    bit_xfer;
    logic                    sym_done;

    // FSM and datapath
    state_t                  state;
    state_t                  state_next;
    logic                    load;
    logic                    underrun_next;
    logic [SCNT_W-1:0]       sample_cnt;
    logic [PHASE_W-1:0]      carrier_acc;
    logic [PHASE_W-1:0]      acc_inc;
    logic [BITS_PER_SYM-1:0] mapped_idx;
    logic [BITS_PER_SYM-1:0] tx_idx;

    // Registered outputs
    logic [BITS_PER_SYM-1:0] sym_out_r;
    logic                    sym_valid_r;
    logic                    sym_strobe_r;
    logic [PHASE_W-1:0]      phase_out_r;
    logic                    underrun_r;

    function automatic logic [BITS_PER_SYM-1:0] gray2bin(input logic [BITS_PER_SYM-1:0] g);
        logic [BITS_PER_SYM-1:0] b;
        b[BITS_PER_SYM-1] = g[BITS_PER_SYM-1];
        for (int i = BITS_PER_SYM - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PHASE_W-1:0] offset_of(input logic [BITS_PER_SYM-1:0] idx);
        return PHASE_W'(idx) << OFS_SH;
    endfunction

    // A refill may land in the same cycle the FSM drains the pending slot, so no bubble.
    assign bus.bit_ready = rst & ((cnt != CNT_LAST) | ~pend_full | pend_take);
    assign bit_xfer      = bus.bit_valid & bus.bit_ready;
    assign sym_done      = bit_xfer & (cnt == CNT_LAST);
    assign word_next     = (shreg << 1) | BITS_PER_SYM'(bus.bit_in);

    assign mapped_idx = (GRAY != 0) ? gray2bin(pend_word) : pend_word;
    assign acc_inc    = carrier_acc + STEP;
    assign pend_take  = load;

`ifdef MPSK_DIFF_ENC_EN
    logic [BITS_PER_SYM-1:0] prev_idx;

    // Transmitted index accumulates modulo M; survives IDLE, cleared only by reset.
    assign tx_idx = prev_idx + mapped_idx;

    // Remember the last transmitted index on every load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_idx <= '0;
        end else if (load) begin
            prev_idx <= tx_idx;
        end
    end
`else
    assign tx_idx = mapped_idx;
`endif

    // Shift bits in MSB first; counter wraps on the symbol-completing transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (bit_xfer) begin
            shreg <= word_next;
            cnt   <= sym_done ? '0 : cnt + 1'b1;
        end
    end

    // One-entry pending buffer; a completed word wins over a same-cycle drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_full <= 1'b0;
            pend_word <= '0;
        end else if (sym_done) begin
            pend_full <= 1'b1;
            pend_word <= word_next;
        end else if (pend_take) begin
            pend_full <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, symbol load and underrun decision; an enable-driven stop is not an underrun.
    always_comb begin
        state_next    = state;
        load          = 1'b0;
        underrun_next = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable && pend_full) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (sample_cnt == SCNT_LAST) begin
                    if (bus.enable && pend_full) begin
                        load = 1'b1;
                    end else begin
                        state_next    = IDLE;
                        underrun_next = bus.enable;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sample counter, carrier accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt   <= '0;
            carrier_acc  <= '0;
            sym_out_r    <= '0;
            sym_valid_r  <= 1'b0;
            sym_strobe_r <= 1'b0;
            phase_out_r  <= '0;
            underrun_r   <= 1'b0;
        end else begin
            sym_strobe_r <= load;
            underrun_r   <= underrun_next;
            if (load) begin
                sample_cnt  <= '0;
                carrier_acc <= '0;
                sym_out_r   <= tx_idx;
                sym_valid_r <= 1'b1;
                phase_out_r <= offset_of(tx_idx);
            end else if (state_next == RUN) begin
                sample_cnt  <= sample_cnt + 1'b1;
                carrier_acc <= acc_inc;
                phase_out_r <= acc_inc + offset_of(sym_out_r);
            end else begin
                // Idle: sym_out keeps the last symbol, phase parks at zero.
                sample_cnt  <= '0;
                carrier_acc <= '0;
                sym_valid_r <= 1'b0;
                phase_out_r <= '0;
            end
        end
    end

    assign bus.sym_out    = sym_out_r;
    assign bus.sym_valid  = sym_valid_r;
    assign bus.sym_strobe = sym_strobe_r;
    assign bus.phase_out  = phase_out_r;
    assign bus.underrun   = underrun_r;
endmodule

// File: tb/tb_mpsk_symbol_mapper.sv
// Bench for mpsk_symbol_mapper (QPSK, 8 samples/symbol, 8-bit phase, Gray).
// Symbol table drives stimulus; expected indices queue up and a monitor checks every output sample.
// Hand-written sequences cover backpressure, enable drop and async reset mid-symbol.
module tb_mpsk_symbol_mapper;
    localparam int B   = 2;
    localparam int SPS = 8;
    localparam int PW  = 8;
    localparam int M   = 1 << B;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mpsk_symbol_mapper_if #(.BITS_PER_SYM(B), .PHASE_W(PW)) bus ();

    mpsk_symbol_mapper #(
        .BITS_PER_SYM   (B),
        .SAMPLES_PER_SYM(SPS),
        .PHASE_W        (PW),
        .GRAY           (1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [B-1:0] word;
        int           idx;
    } vec_t;

    vec_t tbl [4];

    int n_checks   = 0;
    int n_errors   = 0;
    int exp_q[$];
    int prev_model = 0;

    int cur_idx    = 0;
    int samp       = 0;
    bit in_sym     = 1'b0;
    int n_underrun = 0;
    int n_strobe   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired or event missing (t=%0t)", name, $time);
    endtask

    function automatic int phase_of(input int idx, input int s);
        return ((idx << (PW - B)) + s * ((1 << PW) / SPS)) % (1 << PW);
    endfunction

    function automatic void push_exp(input int idx);
        int e;
`ifdef MPSK_DIFF_ENC_EN
        e          = (prev_model + idx) % M;
        prev_model = e;
`else
        e = idx;
`endif
        exp_q.push_back(e);
    endfunction

    task automatic send_bit(input logic b);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        #1;
        while (bus.bit_ready !== 1'b1 && guard < 400) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 400) fail_now("bit_ready_timeout");
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_sym(input vec_t v);
        push_exp(v.idx);
        send_bit(v.word[1]);
        send_bit(v.word[0]);
    endtask

    task automatic wait_strobe(input string name);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (bus.sym_strobe !== 1'b1 && guard < 100);
        if (bus.sym_strobe !== 1'b1) fail_now(name);
    endtask

    // Returns one negedge after the underrun pulse so the monitor has counted it.
    task automatic wait_underrun(input string name);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (bus.underrun !== 1'b1 && guard < 200);
        if (bus.underrun !== 1'b1) begin
            fail_now(name);
        end else begin
            chk({name, "_valid"}, bus.sym_valid, 0);
            chk({name, "_phase"}, bus.phase_out, 0);
        end
        @(negedge clk);
    endtask

    // Output monitor: pops an expected index on each strobe and checks every sample.
    always @(negedge clk) begin
        if (!rst) begin
            in_sym = 1'b0;
            samp   = 0;
        end else begin
            if (bus.underrun) n_underrun++;
            if (bus.sym_strobe) begin
                n_strobe++;
                if (in_sym) chk("sym_len_b2b", samp, SPS);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_symbol");
                    cur_idx = bus.sym_out;
                end else begin
                    cur_idx = exp_q.pop_front();
                    chk("sym_out", bus.sym_out, cur_idx);
                end
                samp   = 0;
                in_sym = 1'b1;
            end
            if (bus.sym_valid) begin
                if (!in_sym) fail_now("valid_without_strobe");
                chk("phase_out", bus.phase_out, phase_of(cur_idx, samp));
                samp++;
            end else begin
                if (in_sym) begin
                    chk("sym_len", samp, SPS);
                    in_sym = 1'b0;
                end
                chk("idle_phase", bus.phase_out, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0;
        int s0;

        tbl[0] = '{word: 2'b00, idx: 0};
        tbl[1] = '{word: 2'b01, idx: 1};
        tbl[2] = '{word: 2'b11, idx: 2};
        tbl[3] = '{word: 2'b10, idx: 3};

        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.enable    = 1'b0;

        // Reset held three cycles, then released.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_bit_ready", bus.bit_ready, 0);
        chk("rst_sym_valid", bus.sym_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_bit_ready", bus.bit_ready, 1);
        chk("post_rst_sym_valid", bus.sym_valid, 0);
        chk("post_rst_sym_out", bus.sym_out, 0);
        chk("post_rst_phase", bus.phase_out, 0);
        chk("post_rst_strobe", bus.sym_strobe, 0);
        chk("post_rst_underrun", bus.underrun, 0);

        // Single isolated symbols from the table, each ending in one underrun.
        bus.enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            u0 = n_underrun;
            send_sym(tbl[i]);
            @(negedge clk);
            chk("latency_not_yet", bus.sym_strobe, 0);
            @(negedge clk);
            chk("latency_strobe", bus.sym_strobe, 1);
            wait_underrun("single_underrun");
            chk("single_underrun_cnt", n_underrun - u0, 1);
        end

        // Continuous stream 01,10,00: three strobes, one underrun at the end.
        u0 = n_underrun;
        s0 = n_strobe;
        send_sym(tbl[1]);
        send_sym(tbl[3]);
        send_sym(tbl[0]);
        wait_underrun("stream_underrun");
        chk("stream_underrun_cnt", n_underrun - u0, 1);
        chk("stream_strobe_cnt", n_strobe - s0, 3);

        // Backpressure with enable low: pending full, collector holds one bit.
        bus.enable = 1'b0;
        send_sym(tbl[1]);
        push_exp(tbl[3].idx);
        send_bit(tbl[3].word[1]);
        @(negedge clk);
        bus.bit_in    = tbl[3].word[0];
        bus.bit_valid = 1'b1;
        #1;
        chk("bp_ready_low", bus.bit_ready, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("bp_ready_low", bus.bit_ready, 0);
            chk("bp_idle", bus.sym_valid, 0);
        end
        @(negedge clk);
        bus.enable = 1'b1;
        #1;
        chk("bp_ready_back", bus.bit_ready, 1);
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
        @(negedge clk);
        chk("bp_start", bus.sym_strobe, 1);
        send_sym(tbl[2]);
        wait_underrun("bp_underrun");

        // Enable dropped at sample 3 with a symbol pending.
        u0 = n_underrun;
        send_sym(tbl[2]);
        wait_strobe("en_drop_first");
        send_sym(tbl[3]);
        @(negedge clk);
        bus.enable = 1'b0;
        repeat (12) @(negedge clk);
        chk("en_drop_no_underrun", n_underrun - u0, 0);
        chk("en_drop_idle", bus.sym_valid, 0);
        chk("en_drop_pending_kept", exp_q.size(), 1);
        bus.enable = 1'b1;
        @(negedge clk);
        chk("en_resume_strobe", bus.sym_strobe, 1);
        wait_underrun("en_resume_underrun");

        // Async reset at sample 4, between clock edges.
        send_sym(tbl[2]);
        wait_strobe("arst_symbol");
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_sym_valid", bus.sym_valid, 0);
        chk("arst_phase", bus.phase_out, 0);
        chk("arst_sym_out", bus.sym_out, 0);
        chk("arst_strobe", bus.sym_strobe, 0);
        chk("arst_bit_ready", bus.bit_ready, 0);
        exp_q.delete();
        prev_model = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        u0 = n_underrun;
        send_sym(tbl[1]);
        send_sym(tbl[1]);
        wait_underrun("post_arst_underrun");
        chk("post_arst_underrun_cnt", n_underrun - u0, 1);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
